// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed seven-segment scanner with per-slot anti-ghosting blank interval
module seg7_scan_driver #(
    parameter int DIGITS           = 4,
    parameter int SCAN_DIV         = 100000,
    parameter int BLANK_CYCLES     = 1000,
    parameter bit ANODE_ACTIVE_LOW = 1,
    parameter bit SEG_ACTIVE_LOW   = 1,
    localparam int AW = DIGITS > 1 ? $clog2(DIGITS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic              wr_raw,
    input  logic [7:0]        wr_data,
    output logic [DIGITS-1:0] ano,
    output logic [7:0]        BCDs,
    output logic              frame_tick
);
    localparam int CW = $clog2(SCAN_DIV);
    logic [7:0]    regs [DIGITS];
    logic [CW-1:0] cnt;
    logic [AW-1:0] ptr;
    logic [6:0]    hex;
    logic [7:0]    wval;
    logic          blank, slot_end, last;
    always_comb begin
        case (wr_data[3:0])
            4'h0: hex = 7'h3F;
            4'h1: hex = 7'h06;
            4'h2: hex = 7'h5B;
            4'h3: hex = 7'h4F;
            4'h4: hex = 7'h66;
            4'h5: hex = 7'h6D;
            4'h6: hex = 7'h7D;
            4'h7: hex = 7'h07;
            4'h8: hex = 7'h7F;
            4'h9: hex = 7'h6F;
            4'hA: hex = 7'h77;
            4'hB: hex = 7'h7C;
            4'hC: hex = 7'h39;
            4'hD: hex = 7'h5E;
            4'hE: hex = 7'h79;
            default: hex = 7'h71;
        endcase
        wval     = wr_raw ? wr_data : {wr_data[4], hex};
        blank    = 32'(cnt) < BLANK_CYCLES;
        slot_end = 32'(cnt) == SCAN_DIV - 1;
        last     = 32'(ptr) == DIGITS - 1;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            ptr        <= '0;
            for (int i = 0; i < DIGITS; i++) regs[i] <= '0;
            ano        <= {DIGITS{ANODE_ACTIVE_LOW}};
            BCDs       <= {8{SEG_ACTIVE_LOW}};
            frame_tick <= 1'b0;
        end else begin
            cnt        <= slot_end ? '0 : cnt + 1'b1;
            if (slot_end) ptr <= last ? '0 : ptr + 1'b1;
            if (wr_en && 32'(wr_addr) < DIGITS) regs[wr_addr] <= wval;
            ano        <= (blank ? '0 : DIGITS'(1) << ptr) ^ {DIGITS{ANODE_ACTIVE_LOW}};
            BCDs       <= (blank ? 8'h00 : regs[ptr]) ^ {8{SEG_ACTIVE_LOW}};
            frame_tick <= slot_end && last;
        end
    end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed checks of scan timing, decode, writes and reset
module tb_seg7_scan_driver;
    logic       clk = 0, reset = 1, wr_en = 0, wr_raw = 0;
    logic [1:0] wr_addr = 0;
    logic [7:0] wr_data = 0;
    logic [3:0] ano;
    logic [7:0] bcds;
    logic       frame_tick;
    logic       w3_en = 0;
    logic [1:0] w3_addr = 0;
    logic [2:0] ano3;
    logic [7:0] bcds3;
    logic       ft3;
    int vectors = 0, miscompares = 0;
    int pulses;
    logic [7:0] exp_seg [4];
    logic [3:0] ea;
    logic [7:0] eb;

    seg7_scan_driver #(.DIGITS(4), .SCAN_DIV(8), .BLANK_CYCLES(2),
                       .ANODE_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_raw(wr_raw),
        .wr_data(wr_data), .ano(ano), .BCDs(bcds), .frame_tick(frame_tick));

    seg7_scan_driver #(.DIGITS(3), .SCAN_DIV(4), .BLANK_CYCLES(1),
                       .ANODE_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)) dut3 (
        .clk(clk), .reset(reset), .wr_en(w3_en), .wr_addr(w3_addr), .wr_raw(1'b1),
        .wr_data(8'hFF), .ano(ano3), .BCDs(bcds3), .frame_tick(ft3));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic raw, input logic [7:0] d);
        wr_en = 1; wr_addr = a; wr_raw = raw; wr_data = d;
        tick();
        wr_en = 0;
    endtask

    task automatic sync();
        int n = 0;
        do begin
            tick();
            n++;
        end while (!frame_tick && n < 100);
        if (!frame_tick) chk("sync_timeout", 0, 1);
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_ano", ano, 4'hF);
        chk("rst_bcd", bcds, 8'hFF);
        chk("rst_ft", frame_tick, 0);
        reset = 0;
        tick(); chk("rel1_ano", ano, 4'hF);
        tick(); chk("rel2_ano", ano, 4'hF);
        tick(); chk("rel3_ano", ano, 4'hE); chk("rel3_bcd", bcds, 8'hFF);

        wr(0, 0, 8'h00);
        wr(1, 0, 8'h09);
        wr(2, 0, 8'h1A);
        wr(3, 0, 8'hEF);
        exp_seg[0] = 8'hC0; exp_seg[1] = 8'h90; exp_seg[2] = 8'h08; exp_seg[3] = 8'h8E;
        sync();
        for (int k = 1; k <= 32; k++) begin
            tick();
            ea = ((k - 1) % 8 < 2) ? 4'hF : ~(4'b0001 << ((k - 1) / 8));
            eb = ((k - 1) % 8 < 2) ? 8'hFF : exp_seg[(k - 1) / 8];
            chk("hex_ano", ano, ea);
            chk("hex_bcd", bcds, eb);
            chk("hex_ft", frame_tick, k == 32);
        end

        sync();
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 12) begin chk("live_old_ano", ano, 4'hD); chk("live_old_bcd", bcds, 8'h90); end
            if (k == 13) begin chk("live_new_ano", ano, 4'hD); chk("live_new_bcd", bcds, 8'hB0); end
            if (k == 16) begin chk("adv_last_ano", ano, 4'hD); chk("adv_last_bcd", bcds, 8'hB0); end
            if (k == 17) begin chk("adv_blank_ano", ano, 4'hF); chk("adv_blank_bcd", bcds, 8'hFF); end
            if (k == 19) begin chk("raw_ano", ano, 4'hB); chk("raw_bcd", bcds, 8'hB6); end
            wr_en = (k == 11) || (k == 15);
            wr_addr = (k == 11) ? 2'd1 : 2'd2;
            wr_raw = (k == 15);
            wr_data = (k == 11) ? 8'h03 : 8'h49;
        end
        wr_en = 0;

        sync();
        pulses = 0;
        for (int k = 1; k <= 128; k++) begin
            tick();
            pulses += int'(frame_tick);
            chk("ft_period", frame_tick, k % 32 == 0);
            if (k % 32 == 0) chk("ft_with_last_anode", ano, 4'h7);
        end
        chk("ft_count", pulses, 4);

        sync();
        repeat (17) tick();
        reset = 1;
        wr_en = 1; wr_addr = 0; wr_raw = 0; wr_data = 8'h08;
        tick();
        chk("mid_rst_ano", ano, 4'hF);
        chk("mid_rst_bcd", bcds, 8'hFF);
        chk("mid_rst_ft", frame_tick, 0);
        reset = 0; wr_en = 0;
        for (int k = 1; k <= 19; k++) begin
            tick();
            if (k < 3) chk("restart_blank", ano, 4'hF);
            if (k == 3) begin chk("restart_ano0", ano, 4'hE); chk("restart_bcd0", bcds, 8'hFF); end
            if (k == 19) begin chk("restart_ano2", ano, 4'hB); chk("restart_bcd2", bcds, 8'hFF); end
        end

        w3_en = 1; w3_addr = 2'd3;
        tick();
        w3_en = 0;
        for (int k = 0; k < 24; k++) begin
            tick();
            chk("oob_bcd", bcds3, 8'hFF);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
